// File: rtl/ones_serializer_pkg.sv
// Shared definitions for the ones serializer: default frame geometry,
// count-width derivation, frame alignment modes and the FSM state type.
package ones_serializer_pkg;

  localparam int DEF_WIDTH = 7;

  // Bits needed to hold every count from 0 up to and including w.
  function automatic int countWidth(input int w);
    return $clog2(w + 1);
  endfunction

  localparam int DEF_CW = countWidth(DEF_WIDTH);

  localparam logic MODE_LOW  = 1'b0;
  localparam logic MODE_HIGH = 1'b1;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_e;

endpackage

// File: rtl/ones_expand.sv
// Combinational expander: a ones count plus an alignment mode becomes a
// WIDTH-bit pattern with the ones packed against the low or high end.
module ones_expand
  import ones_serializer_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CW    = countWidth(WIDTH)
) (
  input  logic [CW-1:0]    count_i,
  input  logic             mode_i,
  output logic [WIDTH-1:0] pattern_o
);

  always_comb begin
    pattern_o = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (mode_i == MODE_HIGH) begin
        pattern_o[i] = (i >= (WIDTH - int'(count_i)));
      end else begin
        pattern_o[i] = (i < int'(count_i));
      end
    end
  end

endmodule

// File: rtl/ones_serializer.sv
// Builds a frame holding a requested number of ones, publishes it as a
// parallel word and shifts it out LSB first under ready/valid handshake.
module ones_serializer
  import ones_serializer_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CW    = countWidth(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [CW-1:0]    in_count,
  input  logic             in_mode,
  output logic [WIDTH-1:0] word_o,
  output logic             word_valid,
  output logic             ser_o,
  output logic             ser_valid,
  input  logic             ser_ready,
  output logic             ser_first,
  output logic             ser_last,
  output logic [CW-1:0]    sent_ones
);

  localparam logic [CW-1:0] LAST_IDX   = CW'(WIDTH - 1);
  localparam logic [CW-1:0] FULL_COUNT = CW'(WIDTH);

  state_e           state_q;
  logic [WIDTH-1:0] word_q;
  logic             wordValid_q;
  logic [WIDTH-1:0] shift_q;
  logic [CW-1:0]    idx_q;
  logic             serValid_q;
  logic             serFirst_q;
  logic             serLast_q;
  logic [CW-1:0]    sentOnes_q;

  logic [CW-1:0]    satCount_d;
  logic [CW-1:0]    idx_d;
  logic [CW-1:0]    sentOnes_d;
  logic [WIDTH-1:0] pattern;

  // Counts beyond the frame length clamp to a completely full frame.
  always_comb begin
    satCount_d = (int'(in_count) > WIDTH) ? FULL_COUNT : in_count;
    idx_d      = idx_q + 1'b1;
    sentOnes_d = (shift_q[0] && (sentOnes_q != FULL_COUNT)) ? sentOnes_q + 1'b1 : sentOnes_q;
  end

  ones_expand #(
    .WIDTH(WIDTH),
    .CW   (CW)
  ) u_expand (
    .count_i  (satCount_d),
    .mode_i   (in_mode),
    .pattern_o(pattern)
  );

  // The shift register drains towards bit 0 and fills with zeros, so ser_o
  // naturally rests at 0 once a frame has been fully sent.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      word_q      <= '0;
      wordValid_q <= 1'b0;
      shift_q     <= '0;
      idx_q       <= '0;
      serValid_q  <= 1'b0;
      serFirst_q  <= 1'b0;
      serLast_q   <= 1'b0;
      sentOnes_q  <= '0;
    end else begin
      wordValid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            state_q     <= SHIFT;
            word_q      <= pattern;
            wordValid_q <= 1'b1;
            shift_q     <= pattern;
            idx_q       <= '0;
            serValid_q  <= 1'b1;
            serFirst_q  <= 1'b1;
            serLast_q   <= (LAST_IDX == '0);
            sentOnes_q  <= '0;
          end
        end
        SHIFT: begin
          if (ser_ready) begin
            shift_q    <= shift_q >> 1;
            sentOnes_q <= sentOnes_d;
            serFirst_q <= 1'b0;
            if (idx_q == LAST_IDX) begin
              state_q    <= IDLE;
              idx_q      <= '0;
              serValid_q <= 1'b0;
              serLast_q  <= 1'b0;
            end else begin
              idx_q     <= idx_d;
              serLast_q <= (idx_d == LAST_IDX);
            end
          end
        end
      endcase
    end
  end

  // Gated by rst directly so the block never advertises readiness in reset.
  assign in_ready   = (state_q == IDLE) && !rst;
  assign word_o     = word_q;
  assign word_valid = wordValid_q;
  assign ser_o      = shift_q[0];
  assign ser_valid  = serValid_q;
  assign ser_first  = serFirst_q;
  assign ser_last   = serLast_q;
  assign sent_ones  = sentOnes_q;

endmodule

// File: tb/tb_ones_serializer.sv
// Bench for ones_serializer: a queue-based frame model checked every cycle,
// plus directed frames with hand-computed expectations and random traffic.
module tb_ones_serializer;

  localparam int W = 7;
  localparam int C = 3;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [C-1:0] in_count;
  logic         in_mode;
  logic [W-1:0] word_o;
  logic         word_valid;
  logic         ser_o;
  logic         ser_valid;
  logic         ser_ready;
  logic         ser_first;
  logic         ser_last;
  logic [C-1:0] sent_ones;

  int checks = 0;
  int errors = 0;

  ones_serializer #(
    .WIDTH(W),
    .CW   (C)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_count  (in_count),
    .in_mode   (in_mode),
    .word_o    (word_o),
    .word_valid(word_valid),
    .ser_o     (ser_o),
    .ser_valid (ser_valid),
    .ser_ready (ser_ready),
    .ser_first (ser_first),
    .ser_last  (ser_last),
    .sent_ones (sent_ones)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", name, actual, expected, $time);
    end
  endtask

  // Frame model: the bits still to be sent sit in a queue, oldest first.
  bit           expQ[$];
  int           expSent = 0;
  logic [W-1:0] expWord = '0;
  bit           expWv = 1'b0;
  bit           modelOn = 1'b0;

  function automatic logic [W-1:0] framePattern(input int cnt, input bit mode);
    int n    = (cnt > W) ? W : cnt;
    int ones = (1 << n) - 1;
    return mode ? W'(ones << (W - n)) : W'(ones);
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      expQ.delete();
      expSent = 0;
      expWord = '0;
      expWv   = 1'b0;
      modelOn = 1'b1;
    end else if (modelOn) begin
      expWv = 1'b0;
      if (expQ.size() == 0) begin
        if (in_valid) begin
          expWord = framePattern(int'(in_count), in_mode);
          expWv   = 1'b1;
          expSent = 0;
          for (int i = 0; i < W; i++) expQ.push_back(expWord[i]);
        end
      end else if (ser_ready) begin
        if (expQ[0]) expSent++;
        void'(expQ.pop_front());
      end
    end
  end

  always @(negedge clk) begin
    if (modelOn) begin
      checkOutput("in_ready", in_ready, (expQ.size() == 0) && !rst);
      checkOutput("ser_valid", ser_valid, expQ.size() != 0);
      checkOutput("ser_o", ser_o, (expQ.size() != 0) ? expQ[0] : 1'b0);
      checkOutput("ser_first", ser_first, expQ.size() == W);
      checkOutput("ser_last", ser_last, expQ.size() == 1);
      checkOutput("word_o", word_o, expWord);
      checkOutput("word_valid", word_valid, expWv);
      checkOutput("sent_ones", sent_ones, expSent);
    end
  end

  // Sends one frame, optionally stalling the sink at a given bit, and
  // returns the collected serial bits and the cycles the transfer took.
  task automatic applyStimulus(input int cnt, input bit mode, input int stallAt, input int stallLen,
                               input logic [W-1:0] litWord, output logic [W-1:0] bits, output int cycles);
    int waitCnt = 0;
    int idx = 0;
    int stalled = 0;
    in_count  = C'(cnt);
    in_mode   = mode;
    in_valid  = 1'b1;
    ser_ready = 1'b1;
    while (in_ready !== 1'b1 && waitCnt < 50) begin
      @(posedge clk); #1;
      waitCnt++;
    end
    if (waitCnt == 50) begin
      checks++; errors++;
      $display("[TB] FAIL accept_timeout: in_ready never rose");
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    checkOutput("lit_word_o", word_o, litWord);
    checkOutput("lit_word_valid", word_valid, 1'b1);
    bits   = '0;
    cycles = 0;
    while (idx < W && cycles < 100) begin
      if (idx == stallAt && stalled < stallLen) begin
        ser_ready = 1'b0;
        stalled++;
      end else begin
        ser_ready = 1'b1;
      end
      if (ser_valid && ser_ready) begin
        bits[idx] = ser_o;
        if (idx == 0) checkOutput("lit_ser_first", ser_first, 1'b1);
        if (idx == W - 1) checkOutput("lit_ser_last", ser_last, 1'b1);
        idx++;
      end
      @(posedge clk); #1;
      cycles++;
    end
    if (cycles == 100) begin
      checks++; errors++;
      $display("[TB] FAIL frame_timeout: only %0d of %0d bits sent", idx, W);
    end
  endtask

  logic [W-1:0] bits;
  int           cyc;
  logic         vRec[16];
  logic         oRec[16];

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_count = '0; in_mode = 1'b0; ser_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_in_ready", in_ready, 1'b0);
    checkOutput("rst_ser_valid", ser_valid, 1'b0);
    checkOutput("rst_word_o", word_o, 7'b0000000);
    checkOutput("rst_sent_ones", sent_ones, 3'd0);
    rst = 1'b0;
    #1;
    checkOutput("post_rst_in_ready", in_ready, 1'b1);
    @(posedge clk); #1;

    $display("[TB] directed frames");
    applyStimulus(3, 1'b0, -1, 0, 7'b0000111, bits, cyc);
    checkOutput("f3_bits", bits, 7'b0000111);
    checkOutput("f3_cycles", cyc, 7);
    checkOutput("f3_in_ready", in_ready, 1'b1);
    checkOutput("f3_sent", sent_ones, 3'd3);

    applyStimulus(2, 1'b1, -1, 0, 7'b1100000, bits, cyc);
    checkOutput("f2h_bits", bits, 7'b1100000);
    checkOutput("f2h_sent", sent_ones, 3'd2);

    applyStimulus(0, 1'b0, -1, 0, 7'b0000000, bits, cyc);
    checkOutput("f0_bits", bits, 7'b0000000);
    checkOutput("f0_cycles", cyc, 7);
    checkOutput("f0_sent", sent_ones, 3'd0);

    applyStimulus(7, 1'b0, -1, 0, 7'b1111111, bits, cyc);
    checkOutput("f7_bits", bits, 7'b1111111);
    checkOutput("f7_sent", sent_ones, 3'd7);

    applyStimulus(5, 1'b0, 2, 3, 7'b0011111, bits, cyc);
    checkOutput("stall_bits", bits, 7'b0011111);
    checkOutput("stall_cycles", cyc, 10);
    checkOutput("stall_sent", sent_ones, 3'd5);

    $display("[TB] back-to-back frames");
    in_valid = 1'b1; in_count = 3'd1; in_mode = 1'b0; ser_ready = 1'b1;
    for (int k = 1; k <= 15; k++) begin
      @(posedge clk); #1;
      vRec[k] = ser_valid;
      oRec[k] = ser_o;
      if (k == 1) in_count = 3'd6;
      if (k == 9) begin
        in_valid = 1'b0; in_count = 3'd2; in_mode = 1'b1;
      end
    end
    begin
      int gaps = 0;
      logic [W-1:0] first = '0;
      logic [W-1:0] second = '0;
      for (int k = 1; k <= 15; k++) if (vRec[k] !== 1'b1) gaps++;
      for (int k = 0; k < W; k++) begin
        first[k]  = oRec[k + 1];
        second[k] = oRec[k + 9];
      end
      checkOutput("b2b_gap_cycles", gaps, 1);
      checkOutput("b2b_gap_pos", vRec[8], 1'b0);
      checkOutput("b2b_first_bits", first, 7'b0000001);
      checkOutput("b2b_second_bits", second, 7'b0111111);
    end
    @(posedge clk); #1;
    checkOutput("b2b_sent", sent_ones, 3'd6);

    $display("[TB] reset mid-frame");
    in_valid = 1'b1; in_count = 3'd5; in_mode = 1'b0; ser_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    checkOutput("abort_bit4", ser_o, 1'b1);
    rst = 1'b1;
    @(posedge clk); #1;
    checkOutput("abort_ser_valid", ser_valid, 1'b0);
    checkOutput("abort_ser_o", ser_o, 1'b0);
    checkOutput("abort_ser_first", ser_first, 1'b0);
    checkOutput("abort_ser_last", ser_last, 1'b0);
    checkOutput("abort_word_o", word_o, 7'b0000000);
    checkOutput("abort_word_valid", word_valid, 1'b0);
    checkOutput("abort_sent", sent_ones, 3'd0);
    checkOutput("abort_in_ready", in_ready, 1'b0);
    rst = 1'b0;
    #1;
    checkOutput("abort_release_ready", in_ready, 1'b1);
    applyStimulus(5, 1'b0, -1, 0, 7'b0011111, bits, cyc);
    checkOutput("resume_bits", bits, 7'b0011111);
    checkOutput("resume_sent", sent_ones, 3'd5);

    $display("[TB] random traffic");
    for (int i = 0; i < 500; i++) begin
      @(posedge clk); #1;
      rst       = ($urandom_range(0, 79) == 0);
      in_valid  = $urandom_range(0, 1);
      in_count  = C'($urandom_range(0, 7));
      in_mode   = $urandom_range(0, 1);
      ser_ready = ($urandom_range(0, 3) != 0);
    end
    @(posedge clk); #1;
    rst = 1'b0; in_valid = 1'b0; ser_ready = 1'b1;
    repeat (20) @(posedge clk);
    #1;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
